// File: rtl/serial_rx_16x_if.sv
// ---------------------------------------------------------------------------
// serial_rx_16x_if
//   Bundle that connects the 16x-oversampling serial receiver to the rest of
//   the system.
//
//   Signals
//     en16         one-clk enable pulse at 16x the baud rate
//     ser_in       raw serial line, idle high, asynchronous to clk
//     dout         last correctly framed character
//     en_out       one-clk pulse, dout updated this cycle
//     framing_err  sticky, last frame had a stop bit of 0
//     parity_err   sticky parity error (0 when parity support is not built)
//     busy         receiver is inside a frame (state != IDLE)
//
//   Modports
//     slave   the receiver: takes en16/ser_in, drives the result signals
//     master  the environment: drives en16/ser_in, consumes the results
// ---------------------------------------------------------------------------
interface serial_rx_16x_if #(
   parameter int DATA_BITS = 8
);
   logic                 en16;
   logic                 ser_in;
   logic [DATA_BITS-1:0] dout;
   logic                 en_out;
   logic                 framing_err;
   logic                 parity_err;
   logic                 busy;

   modport slave (
      input  en16,
      input  ser_in,
      output dout,
      output en_out,
      output framing_err,
      output parity_err,
      output busy
   );

   modport master (
      output en16,
      output ser_in,
      input  dout,
      input  en_out,
      input  framing_err,
      input  parity_err,
      input  busy
   );
endinterface

// File: rtl/serial_rx_16x.sv
// ---------------------------------------------------------------------------
// serial_rx_16x
//   Asynchronous serial receiver (8-N-1 by default, LSB first). The raw line
//   is brought into the clk domain through two flops, then oversampled on the
//   16x baud enable. The start bit is re-checked at MID_TICK to reject short
//   glitches, after which every later sample lands at the middle of its bit.
//   A received character is presented on dout with a one-clk en_out pulse.
//   A stop bit of 0 flags framing_err and parks the receiver in BREAK until
//   the line goes high again, so a held-low line is not read as 0x00 frames.
//
//   Parameters
//     DATA_BITS  data bits per frame, legal 5..8
//     MID_TICK   en16 tick index inside the start bit used for re-verification
//
//   Ports
//     clk    global clock
//     reset  synchronous, active-high reset
//     bus    serial_rx_16x_if.slave (en16, ser_in in; dout, en_out,
//            framing_err, parity_err, busy out)
//
//   Build option
//     SERIAL_RX_PARITY_EN  when defined the frame is 8-E-1: a PARITY state
//                          follows DATA and parity_err reports even-parity
//                          violations. When undefined parity_err is tied to 0.
// ---------------------------------------------------------------------------
module serial_rx_16x #(
   parameter int DATA_BITS = 8,
   parameter int MID_TICK  = 7
) (
   input  logic              clk,
   input  logic              reset,
   serial_rx_16x_if.slave    bus
);

   localparam logic [3:0] MID_T  = 4'(MID_TICK);
   localparam logic [3:0] LAST_T = 4'd15;
   localparam logic [2:0] LAST_B = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   // Two-flop synchroniser; reset to the idle (high) line level.
   logic r_sync1;
   logic r_sync2;
   logic w_s_rx;

   state_t               r_state;
   state_t               w_state_next;
   logic [3:0]           r_tick;
   logic [3:0]           w_tick_next;
   logic [2:0]           r_bitcnt;
   logic [2:0]           w_bitcnt_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_next;
   logic [DATA_BITS-1:0] r_dout;
   logic [DATA_BITS-1:0] w_dout_next;
   logic                 r_en_out;
   logic                 w_en_out_next;
   logic                 r_ferr;
   logic                 w_ferr_next;
`ifdef SERIAL_RX_PARITY_EN
   logic                 r_perr;
   logic                 w_perr_next;
   logic                 r_par_bit;
   logic                 w_par_bit_next;
`endif

   assign w_s_rx = r_sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.ser_in;
         r_sync2 <= r_sync1;
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_tick    <= 4'd0;
         r_bitcnt  <= 3'd0;
         r_shift   <= '0;
         r_dout    <= '0;
         r_en_out  <= 1'b0;
         r_ferr    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         r_perr    <= 1'b0;
         r_par_bit <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_next;
         r_tick    <= w_tick_next;
         r_bitcnt  <= w_bitcnt_next;
         r_shift   <= w_shift_next;
         r_dout    <= w_dout_next;
         r_en_out  <= w_en_out_next;
         r_ferr    <= w_ferr_next;
`ifdef SERIAL_RX_PARITY_EN
         r_perr    <= w_perr_next;
         r_par_bit <= w_par_bit_next;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next-state / output logic. Everything except en_out only moves on an
   // en16 cycle; en_out defaults low so it is a single-clk pulse.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next   = r_state;
      w_tick_next    = r_tick;
      w_bitcnt_next  = r_bitcnt;
      w_shift_next   = r_shift;
      w_dout_next    = r_dout;
      w_en_out_next  = 1'b0;
      w_ferr_next    = r_ferr;
`ifdef SERIAL_RX_PARITY_EN
      w_perr_next    = r_perr;
      w_par_bit_next = r_par_bit;
`endif

      if (bus.en16) begin
         case (r_state)
            S_IDLE: begin
               if (!w_s_rx) begin
                  w_state_next = S_START;
                  w_tick_next  = 4'd0;
               end
            end

            S_START: begin
               if (r_tick == MID_T) begin
                  w_tick_next = 4'd0;
                  if (w_s_rx) begin
                     // Line went back high before mid start bit: glitch.
                     w_state_next = S_IDLE;
                  end else begin
                     // From here every 16 ticks lands on the middle of a bit.
                     w_bitcnt_next = 3'd0;
                     w_state_next  = S_DATA;
                  end
               end else begin
                  w_tick_next = r_tick + 4'd1;
               end
            end

            S_DATA: begin
               if (r_tick == LAST_T) begin
                  w_tick_next  = 4'd0;
                  // LSB arrives first, so shift right and insert at the top.
                  w_shift_next = {w_s_rx, r_shift[DATA_BITS-1:1]};
                  if (r_bitcnt == LAST_B) begin
                     w_bitcnt_next = 3'd0;
`ifdef SERIAL_RX_PARITY_EN
                     w_state_next  = S_PARITY;
`else
                     w_state_next  = S_STOP;
`endif
                  end else begin
                     w_bitcnt_next = r_bitcnt + 3'd1;
                  end
               end else begin
                  w_tick_next = r_tick + 4'd1;
               end
            end

`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
               if (r_tick == LAST_T) begin
                  w_tick_next    = 4'd0;
                  w_par_bit_next = w_s_rx;
                  w_state_next   = S_STOP;
               end else begin
                  w_tick_next = r_tick + 4'd1;
               end
            end
`endif

            S_STOP: begin
               if (r_tick == LAST_T) begin
                  w_tick_next = 4'd0;
                  if (w_s_rx) begin
                     w_dout_next   = r_shift;
                     w_ferr_next   = 1'b0;
                     w_en_out_next = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                     // Even parity: data XOR parity bit must be 0.
                     w_perr_next   = (^r_shift) ^ r_par_bit;
`endif
                     // Back to IDLE on this same en16 so an immediately
                     // following start edge is not missed.
                     w_state_next  = S_IDLE;
                  end else begin
                     w_ferr_next  = 1'b1;
                     w_state_next = S_BREAK;
                  end
               end else begin
                  w_tick_next = r_tick + 4'd1;
               end
            end

            S_BREAK: begin
               // Hold off until the line is released, so a long low line
               // is one framing error rather than a stream of 0x00 frames.
               if (w_s_rx) begin
                  w_state_next = S_IDLE;
               end
            end

            default: begin
               w_state_next = S_IDLE;
               w_tick_next  = 4'd0;
            end
         endcase
      end
   end

   assign bus.dout        = r_dout;
   assign bus.en_out      = r_en_out;
   assign bus.framing_err = r_ferr;
   assign bus.busy        = (r_state != S_IDLE);
`ifdef SERIAL_RX_PARITY_EN
   assign bus.parity_err  = r_perr;
`else
   assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_16x.sv
// ---------------------------------------------------------------------------
// tb_serial_rx_16x
//   Directed bench for serial_rx_16x. en16 pulses every 4 clk (64 clk/bit).
//   Good frames push their byte into a scoreboard queue when sent; a monitor
//   pops and compares on each en_out pulse.
// ---------------------------------------------------------------------------
module tb_serial_rx_16x;

   localparam int DATA_BITS = 8;
   localparam int BIT_CLK   = 64;
`ifdef SERIAL_RX_PARITY_EN
   localparam int FRAME_CLK = BIT_CLK * (DATA_BITS + 3);
`else
   localparam int FRAME_CLK = BIT_CLK * (DATA_BITS + 2);
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;

   serial_rx_16x_if #(.DATA_BITS(DATA_BITS)) bus ();

   serial_rx_16x #(
      .DATA_BITS (DATA_BITS),
      .MID_TICK  (7)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_pulses = 0;
   int unsigned cyc      = 0;
   int unsigned last_pulse_cyc = 0;
   int unsigned prev_pulse_cyc = 0;
   logic        prev_en  = 1'b0;
   logic [7:0]  exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
         $display("check %-20s obs=%0h exp=%0h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // en16 generator: one clk high out of every four.
   initial begin
      bus.en16 = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         bus.en16 = 1'b1;
         @(negedge clk);
         bus.en16 = 1'b0;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (bus.en_out === 1'b1) begin
         logic [7:0] exp_b;
         n_pulses++;
         prev_pulse_cyc = last_pulse_cyc;
         last_pulse_cyc = cyc;
         check("en_out_single", 32'(prev_en), 32'd0);
         check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            check("sb_dout", 32'(bus.dout), 32'(exp_b));
         end
      end
      prev_en = bus.en_out;
   end

   task automatic drive_bit(input logic b);
      bus.ser_in = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
      drive_bit(par_bit);
`endif
      drive_bit(stop_bit);
      bus.ser_in = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 400 && bus.busy === 1'b1; i++) @(negedge clk);
      check(tag, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      bus.ser_in = 1'b1;
      reset = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_dout",  32'(bus.dout),        32'd0);
      check("rst_en_out",32'(bus.en_out),      32'd0);
      check("rst_ferr",  32'(bus.framing_err), 32'd0);
      check("rst_perr",  32'(bus.parity_err),  32'd0);
      check("rst_busy",  32'(bus.busy),        32'd0);
      repeat (50) @(negedge clk);

      // Single frame 'A'.
      p0 = n_pulses;
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b0, 1'b1);
      wait_idle("A_busy_idle");
      check("A_pulses", 32'(n_pulses), 32'(p0 + 1));
      check("A_dout",   32'(bus.dout), 32'h41);
      check("A_ferr",   32'(bus.framing_err), 32'd0);
      repeat (40) @(negedge clk);

      // Back-to-back '#','9' with no idle gap.
      p0 = n_pulses;
      exp_q.push_back(8'h23);
      exp_q.push_back(8'h39);
      send_frame(8'h23, 1'b1, 1'b1);
      send_frame(8'h39, 1'b0, 1'b1);
      wait_idle("b2b_busy_idle");
      check("b2b_pulses",  32'(n_pulses), 32'(p0 + 2));
      check("b2b_spacing", 32'(last_pulse_cyc - prev_pulse_cyc), 32'(FRAME_CLK));
      check("b2b_dout",    32'(bus.dout), 32'h39);
      repeat (40) @(negedge clk);

      // 8-clk glitch on the idle line.
      p0 = n_pulses;
      bus.ser_in = 1'b0;
      repeat (8) @(negedge clk);
      bus.ser_in = 1'b1;
      repeat (100) @(negedge clk);
      check("glitch_pulses", 32'(n_pulses), 32'(p0));
      check("glitch_dout",   32'(bus.dout), 32'h39);
      check("glitch_ferr",   32'(bus.framing_err), 32'd0);
      check("glitch_busy",   32'(bus.busy), 32'd0);

      // 0x55 with stop bit 0, then line held low (break).
      p0 = n_pulses;
      send_frame(8'h55, 1'b0, 1'b0);
      bus.ser_in = 1'b0;
      repeat (3 * BIT_CLK) @(negedge clk);
      check("brk_ferr",   32'(bus.framing_err), 32'd1);
      check("brk_busy",   32'(bus.busy), 32'd1);
      check("brk_dout",   32'(bus.dout), 32'h39);
      check("brk_pulses", 32'(n_pulses), 32'(p0));
      bus.ser_in = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
      check("brk_release_busy", 32'(bus.busy), 32'd0);
      exp_q.push_back(8'h30);
      send_frame(8'h30, 1'b0, 1'b1);
      wait_idle("after_brk_idle");
      check("after_brk_pulses", 32'(n_pulses), 32'(p0 + 1));
      check("after_brk_dout",   32'(bus.dout), 32'h30);
      check("after_brk_ferr",   32'(bus.framing_err), 32'd0);
      repeat (40) @(negedge clk);

      // Reset in the middle of bit 4 of 0xFF.
      p0 = n_pulses;
      bus.ser_in = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      bus.ser_in = 1'b1;
      repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
      check("mid_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mrst_dout",   32'(bus.dout),        32'd0);
      check("mrst_en_out", 32'(bus.en_out),      32'd0);
      check("mrst_ferr",   32'(bus.framing_err), 32'd0);
      check("mrst_perr",   32'(bus.parity_err),  32'd0);
      check("mrst_busy",   32'(bus.busy),        32'd0);
      repeat (10 * BIT_CLK) @(negedge clk);
      check("mrst_no_pulse", 32'(n_pulses), 32'(p0));
      exp_q.push_back(8'h0D);
      send_frame(8'h0D, 1'b1, 1'b1);
      wait_idle("cr_busy_idle");
      check("cr_dout", 32'(bus.dout), 32'h0D);
      repeat (40) @(negedge clk);

`ifdef SERIAL_RX_PARITY_EN
      // Parity: correct even parity, then wrong parity bit.
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b0, 1'b1);
      wait_idle("par_ok_idle");
      check("par_ok_perr", 32'(bus.parity_err), 32'd0);
      p0 = n_pulses;
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b1, 1'b1);
      wait_idle("par_bad_idle");
      check("par_bad_pulse", 32'(n_pulses), 32'(p0 + 1));
      check("par_bad_perr",  32'(bus.parity_err), 32'd1);
      repeat (40) @(negedge clk);
`endif

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_rx_16x.md
Name: serial_rx_16x

Overview:
- Asynchronous serial receiver (8-N-1, LSB first) for the RS-232C link; the counterpart of the keypad-to-PC sender path.
- Oversamples UART_RXD using the 16x baud enable from clock_en (en_out16) and recovers each character.
- Presents the byte on dout with a one-clk valid pulse, suitable for driving the LCD character port (ds/ascii_in).
- Flags framing errors and rejects start-bit glitches.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first), legal 5..8
MID_TICK, 7, en16 tick index (0-based) inside the start bit at which the start bit is re-verified

Ports:
clk  input  1  global 50 MHz clock
reset  input  1  synchronous, active-high reset
en16  input  1  one-clk enable pulse at 16x baud rate
ser_in  input  1  raw serial line, idle high, asynchronous to clk
dout  output  DATA_BITS  last correctly framed character
en_out  output  1  one-clk pulse: dout updated this cycle
framing_err  output  1  sticky: last frame had stop bit = 0
parity_err  output  1  sticky parity error (see Optional Feature; constant 0 when disabled)
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: dout=0, en_out=0, framing_err=0, parity_err=0, busy=0, state=IDLE, synchroniser flops=1, tick counter=0, bit counter=0.
- Synchroniser: ser_in passes through 2 flops (s_rx) before any use. All sampling uses s_rx.
- Pacing: tick counter (4 bits) and state advance only on clk cycles with en16=1. Exceptions: en_out, which clears on the next clk, and reset.
- IDLE:
  - On en16 with s_rx=0: go to START, tick=0.
- START:
  - tick increments each en16.
  - At tick==MID_TICK: if s_rx=1, treat as a glitch and return to IDLE with no outputs changed.
  - Otherwise set tick=0, bitcnt=0, and go to DATA.
  - This realigns sampling to mid-bit.
- DATA:
  - On en16 with tick==15: shift s_rx into shift[DATA_BITS-1] (right shift, LSB first), set tick=0, bitcnt+1.
  - When bitcnt reaches DATA_BITS-1 and is sampled: go to STOP (or PARITY if enabled).
- STOP: on en16 with tick==15, sample s_rx.
  - s_rx=1: dout<=shift, framing_err<=0, en_out=1 for exactly one clk; go to IDLE.
  - s_rx=0: dout unchanged, no en_out, framing_err<=1; go to BREAK.
- BREAK:
  - Wait for an en16 with s_rx=1, then go to IDLE.
  - Prevents a held-low line (break) from being read as repeated 0x00 frames.
- Latency:
  - en_out asserts on the clk edge following the en16 cycle that samples mid stop bit.
  - This is about 9.5 bit times after the start edge, plus 2 clk for the synchroniser and up to 1 en16 period of detection jitter.
- en_out is never high for two consecutive clks. dout holds until the next good frame.
- Back-to-back frames: a start bit beginning immediately after the stop sample is detected, because IDLE is re-entered on the same en16.
- reset mid-frame:
  - Next cycle is in IDLE with outputs at reset values.
  - A partial frame is discarded.
  - A line still low after reset is treated as a new start edge.
- en16 held high continuously: still legal; the block then behaves as 16 clk per bit.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - Frame becomes 8-E-1.
  - A PARITY state follows DATA and samples at tick==15.
  - parity_err <= (XOR of data bits) ^ sampled bit, updated only on frames whose stop bit = 1; it is sticky until the next such frame.
  - en_out still pulses on a parity error; the consumer checks parity_err.
- Undefined: no PARITY state; parity_err tied to 0.

Test Plan:
- Bench setup: en16 every 4 clk (64 clk/bit). Send 0x41 ('A') as 8-N-1 -> exactly one en_out pulse, dout=0x41, framing_err=0, busy back to 0 after the stop sample.
- 0x23 ('#') immediately followed by 0x39 ('9') with no idle gap -> two en_out pulses about 640 clk apart, dout=0x23 then 0x39.
- 8-clk low glitch (2 ticks) on the idle line -> back to IDLE at tick 7, no en_out, dout unchanged, framing_err=0.
- Frame 0x55 with stop bit forced 0 -> no en_out, framing_err=1, dout keeps its old value. Line then held low for 3 bit times -> stays in BREAK, no frames. Line released, then 0x30 sent -> en_out, dout=0x30, framing_err=0.
- Assert reset during bit 4 of 0xFF -> all outputs 0 on the next clk. Then send 0x0D -> dout=0x0D.
- With SERIAL_RX_PARITY_EN: 0x41 with parity bit 0 -> parity_err=0. Then 0x41 with parity bit 1 -> en_out pulses, parity_err=1.
